sprite_draw_engine: RTL and testbench
=====================================

Name: sprite_draw_engine

Overview:
Responder side of the sprite queue / engine handshake. It latches a sprite target on UPDATE, then on RUN_ENG walks every pixel of the selected sprite. Each pixel is read from the sprite ROM and written to the frame buffer, with transparency and screen clipping applied. It then returns a single-cycle ENG_DONE. It sits between the sprite queue and the frame-buffer SRAM arbiter.

Parameters:
SPRITE_DIM, 16, sprite width and height in pixels (power of two).
SCREEN_W, 320, visible width; x >= SCREEN_W is clipped.
SCREEN_H, 240, visible height; y >= SCREEN_H is clipped.
TRANSPARENT_KEY, 8'hE3, ROM colour index that is never written.

Ports:
CLOCK_50  in  1  50 MHz master clock.
RESET_L  in  1  synchronous, active-low reset.
UPDATE  in  1  latch SPRITE_ID, TARGET_X and TARGET_Y (honoured only in IDLE).
RUN_ENG  in  1  level request to draw the latched sprite.
SPRITE_ID  in  2  sprite code; 2'b11 is the skip opcode.
TARGET_X  in  9  anchor x (top-left).
TARGET_Y  in  9  anchor y (top-left).
ENG_DONE  out  1  one-cycle pulse: sprite finished.
ROM_ADDR  out  10  {id, row[3:0], col[3:0]}.
ROM_DATA  in  8  colour index, valid 1 cycle after ROM_ADDR.
FB_ADDR  out  17  y*SCREEN_W + x.
FB_DATA  out  8  colour index to write.
FB_WE  out  1  write request, held until FB_READY.
FB_READY  in  1  arbiter accepts the write this cycle.

Behaviour:
- Reset (RESET_L=0 at a clock edge), including mid-draw:
  - state goes to IDLE;
  - ENG_DONE, FB_WE, FB_ADDR, FB_DATA, ROM_ADDR, row/col counters and latched id/x/y all go to 0;
  - any pending write is dropped.
- States are IDLE, READ, EVAL, WRITE, DONE, RELEASE.
- IDLE:
  - UPDATE=1 latches id, x and y.
  - RUN_ENG=1 clears row and col to 0. If latched id==2'b11, go to DONE (zero pixels drawn); otherwise go to READ.
  - If UPDATE and RUN_ENG are both high, the latch happens first and RUN_ENG is honoured in the same cycle using the new values.
- READ: ROM_ADDR is driven from {id,row,col}; always go to EVAL.
- EVAL: ROM_DATA is valid. Compute px = x+col and py = y+row as 10-bit sums.
  - Skip the pixel if ROM_DATA==TRANSPARENT_KEY, px>=SCREEN_W or py>=SCREEN_H. No wrap-around: a 9-bit overflow counts as clipped.
  - Skip: advance the counters, then go to READ, or to DONE if this was the last pixel.
  - Otherwise: register FB_ADDR = py*320+px (shift-add) and FB_DATA = ROM_DATA, set FB_WE=1, go to WRITE.
- WRITE: hold FB_WE, FB_ADDR and FB_DATA stable.
  - When FB_READY=1: drop FB_WE next cycle, advance the counters, go to READ or DONE.
  - FB_READY while FB_WE=0 is ignored.
- Counter advance: col increments and wraps to 0 at SPRITE_DIM, carrying into row. The last pixel is row=col=SPRITE_DIM-1.
- DONE: ENG_DONE=1 for exactly one cycle, then go to RELEASE.
- RELEASE: wait until RUN_ENG=0, then go to IDLE. This prevents a double draw if the initiator is slow to drop RUN_ENG.
- RUN_ENG dropping mid-draw is ignored; the sprite always completes.
- UPDATE outside IDLE is ignored.
- Latency is counted from the first IDLE cycle with RUN_ENG=1 (cycle 0):
  - skipped pixel costs 2 cycles;
  - written pixel costs 3 cycles when FB_READY is tied high, plus 1 per stall cycle;
  - ENG_DONE appears at cycle 1 + sum of per-pixel costs;
  - for the skip opcode, ENG_DONE appears at cycle 1.

Decomposition:
- Shared package sprite_pkg holds:
  - SCREEN_W, SCREEN_H, SPRITE_DIM, TRANSPARENT_KEY;
  - ID_SKIP=2'b11;
  - the engine state enum;
  - the sprite_id_t typedef (2 bits) and coord_t typedef (9 bits).
- One sub-module, sprite_pixel_counter. It holds the row/col registers with clear/advance inputs and a last-pixel output.

Test Plan:
1. All-transparent sprite, id=0, x=y=0, FB_READY=1, RUN_ENG held: ENG_DONE pulses at cycle 513, FB_WE is never high, and ENG_DONE is high for exactly 1 cycle.
2. All-opaque sprite (colour 8'h1C), x=10, y=20, FB_READY=1: 256 writes; the first has FB_ADDR=6410 and the last has FB_ADDR=11225 with FB_DATA=8'h1C; ENG_DONE at cycle 769.
3. Clipping, x=312, y=232, opaque: only the 8x8 on-screen pixels (64) are written; the last FB_ADDR is 76799; no FB_ADDR reaches 76800 or above.
4. FB_READY low for 5 cycles on the first write: FB_WE, FB_ADDR and FB_DATA are held constant through the stall; exactly one write is accepted; ENG_DONE arrives 5 cycles later than in scenario 2.
5. SPRITE_ID=2'b11 with UPDATE+RUN_ENG: ENG_DONE at cycle 1 with no writes. The engine stays in RELEASE until RUN_ENG=0 and a second ENG_DONE never appears while RUN_ENG stays high.
6. RESET_L pulsed low mid-write, then UPDATE with x=5 while idle: FB_WE=0 and all outputs are 0 after the reset edge. A new RUN_ENG draws from row=col=0 using the newly latched target.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and types for the sprite draw engine
package sprite_pkg;

  localparam int SPRITE_DIM = 16;
  localparam int CNT_W      = $clog2(SPRITE_DIM);
  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;

  typedef logic [1:0] sprite_id_t;
  typedef logic [8:0] coord_t;

  localparam logic [7:0] TRANSPARENT_KEY = 8'hE3;
  localparam sprite_id_t ID_SKIP         = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_WRITE,
    ST_DONE,
    ST_RELEASE
  } eng_state_t;

endpackage

// File: rtl/sprite_pixel_counter.sv
// rtl/sprite_pixel_counter.sv - row/col walker over one sprite tile
module sprite_pixel_counter
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             last
);

  // col runs fastest and carries into row when it wraps
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == CNT_W'(SPRITE_DIM - 1)) begin
        col <= '0;
        row <= row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

  assign last = (row == CNT_W'(SPRITE_DIM - 1)) && (col == CNT_W'(SPRITE_DIM - 1));

endmodule

// File: rtl/sprite_draw_engine.sv
// rtl/sprite_draw_engine.sv - copies one sprite from ROM into the frame buffer
module sprite_draw_engine
  import sprite_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        RESET_L,
  input  logic        UPDATE,
  input  logic        RUN_ENG,
  input  logic [1:0]  SPRITE_ID,
  input  logic [8:0]  TARGET_X,
  input  logic [8:0]  TARGET_Y,
  output logic        ENG_DONE,
  output logic [9:0]  ROM_ADDR,
  input  logic [7:0]  ROM_DATA,
  output logic [16:0] FB_ADDR,
  output logic [7:0]  FB_DATA,
  output logic        FB_WE,
  input  logic        FB_READY
);

  eng_state_t       state, state_nxt;
  sprite_id_t       id_q, eff_id;
  coord_t           x_q, y_q;
  logic [CNT_W-1:0] row, col;
  logic             last_px;
  logic             cnt_clear, cnt_adv, latch_en, fb_load, fb_release;
  logic [9:0]       px, py;
  logic             pixel_skip;
  logic [16:0]      fb_addr_calc;

  sprite_pixel_counter u_counter (
    .clk     (CLOCK_50),
    .resetn  (RESET_L),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .row     (row),
    .col     (col),
    .last    (last_px)
  );

  // an UPDATE in the same cycle as RUN_ENG must steer the skip decision
  assign eff_id = UPDATE ? SPRITE_ID : id_q;

  // 10-bit sums so a 9-bit overflow lands off-screen instead of wrapping
  assign px = {1'b0, x_q} + {{(10 - CNT_W){1'b0}}, col};
  assign py = {1'b0, y_q} + {{(10 - CNT_W){1'b0}}, row};

  assign pixel_skip = (ROM_DATA == TRANSPARENT_KEY) ||
                      (px >= 10'(SCREEN_W)) || (py >= 10'(SCREEN_H));

  // py*320 as py*256 + py*64
  assign fb_addr_calc = ({7'd0, py} << 8) + ({7'd0, py} << 6) + {7'd0, px};

  assign ROM_ADDR = {id_q, row, col};

  // state register
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (RUN_ENG) state_nxt = (eff_id == ID_SKIP) ? ST_DONE : ST_READ;
      ST_READ:    state_nxt = ST_EVAL;
      ST_EVAL: begin
        if (!pixel_skip)  state_nxt = ST_WRITE;
        else if (last_px) state_nxt = ST_DONE;
        else              state_nxt = ST_READ;
      end
      ST_WRITE:   if (FB_READY) state_nxt = last_px ? ST_DONE : ST_READ;
      ST_DONE:    state_nxt = ST_RELEASE;
      ST_RELEASE: if (!RUN_ENG) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // per-state control strobes
  always_comb begin
    ENG_DONE   = 1'b0;
    latch_en   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_adv    = 1'b0;
    fb_load    = 1'b0;
    fb_release = 1'b0;
    case (state)
      ST_IDLE: begin
        latch_en  = UPDATE;
        cnt_clear = RUN_ENG;
      end
      ST_EVAL: begin
        cnt_adv = pixel_skip;
        fb_load = !pixel_skip;
      end
      ST_WRITE: begin
        cnt_adv    = FB_READY;
        fb_release = FB_READY;
      end
      ST_DONE: ENG_DONE = 1'b1;
      default: ;
    endcase
  end

  // target latch, only open while idle
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_L) begin
      id_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (latch_en) begin
      id_q <= SPRITE_ID;
      x_q  <= TARGET_X;
      y_q  <= TARGET_Y;
    end
  end

  // frame-buffer write request, held stable until the arbiter accepts it
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_L) begin
      FB_WE   <= 1'b0;
      FB_ADDR <= '0;
      FB_DATA <= '0;
    end else if (fb_load) begin
      FB_WE   <= 1'b1;
      FB_ADDR <= fb_addr_calc;
      FB_DATA <= ROM_DATA;
    end else if (fb_release) begin
      FB_WE   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// tb/tb_sprite_draw_engine.sv - self-checking bench for sprite_draw_engine
module tb_sprite_draw_engine;

  localparam logic [7:0] KEY = 8'hE3;
  localparam int SW = 320;
  localparam int SH = 240;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_L = 1'b0;
  logic        UPDATE = 1'b0;
  logic        RUN_ENG = 1'b0;
  logic [1:0]  SPRITE_ID = '0;
  logic [8:0]  TARGET_X = '0;
  logic [8:0]  TARGET_Y = '0;
  logic        ENG_DONE;
  logic [9:0]  ROM_ADDR;
  logic [7:0]  ROM_DATA = '0;
  logic [16:0] FB_ADDR;
  logic [7:0]  FB_DATA;
  logic        FB_WE;
  logic        FB_READY = 1'b1;

  sprite_draw_engine dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_L   (RESET_L),
    .UPDATE    (UPDATE),
    .RUN_ENG   (RUN_ENG),
    .SPRITE_ID (SPRITE_ID),
    .TARGET_X  (TARGET_X),
    .TARGET_Y  (TARGET_Y),
    .ENG_DONE  (ENG_DONE),
    .ROM_ADDR  (ROM_ADDR),
    .ROM_DATA  (ROM_DATA),
    .FB_ADDR   (FB_ADDR),
    .FB_DATA   (FB_DATA),
    .FB_WE     (FB_WE),
    .FB_READY  (FB_READY)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [7:0] rom_mem [0:1023];
  always @(posedge CLOCK_50) ROM_DATA <= rom_mem[ROM_ADDR];

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // passive observer of the frame-buffer port and done pulses
  int wr_addr_q[$];
  int wr_data_q[$];
  int done_cyc_q[$];
  int stall_cnt = 0;
  int hold_viol = 0;
  int max_addr = 0;
  int we_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;

  always @(negedge CLOCK_50) begin
    if (RESET_L) begin
      if (prev_stall && (!FB_WE || FB_ADDR != prev_addr || FB_DATA != prev_data))
        hold_viol <= hold_viol + 1;
      if (FB_WE) begin
        we_cnt <= we_cnt + 1;
        if (int'(FB_ADDR) > max_addr) max_addr <= int'(FB_ADDR);
      end
      if (FB_WE && FB_READY) begin
        wr_addr_q.push_back(int'(FB_ADDR));
        wr_data_q.push_back(int'(FB_DATA));
      end
      if (FB_WE && !FB_READY) stall_cnt <= stall_cnt + 1;
      if (ENG_DONE) done_cyc_q.push_back(cyc);
    end
    prev_stall <= RESET_L && FB_WE && !FB_READY;
    prev_addr  <= FB_ADDR;
    prev_data  <= FB_DATA;
  end

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int stall_left = 0;
  bit noise = 1'b0;

  int exp_addr_q[$];
  int exp_data_q[$];
  int exp_cost;

  int r_writes, r_first, r_last, r_last_data, r_done_rel, r_we, r_stalls, r_hold;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    case (ready_mode)
      1: FB_READY = ($urandom_range(0, 2) != 0);
      2: begin
        if (FB_WE && stall_left > 0) begin
          FB_READY = 1'b0;
          stall_left--;
        end else begin
          FB_READY = 1'b1;
        end
      end
      default: FB_READY = 1'b1;
    endcase
    if (noise) begin
      UPDATE    = 1'($urandom_range(0, 1));
      SPRITE_ID = 2'($urandom);
      TARGET_X  = 9'($urandom);
      TARGET_Y  = 9'($urandom);
    end else begin
      UPDATE = 1'b0;
    end
  endtask

  // mode 0: all transparent, 1: solid colour, 2: random with ~30% transparent
  task automatic fill(input int id, input int mode, input int color);
    for (int i = 0; i < 256; i++) begin
      if (mode == 0)      rom_mem[id*256 + i] = KEY;
      else if (mode == 1) rom_mem[id*256 + i] = color[7:0];
      else if ($urandom_range(0, 9) < 3) rom_mem[id*256 + i] = KEY;
      else                rom_mem[id*256 + i] = 8'($urandom);
    end
  endtask

  // reference: raster-order list of visible pixels and the cycle cost of the walk
  task automatic model(input int id, input int x, input int y);
    int c, px, py;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_cost = 0;
    if (id == 3) return;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 16; k++) begin
        c  = int'(rom_mem[id*256 + r*16 + k]);
        px = x + k;
        py = y + r;
        if (c != int'(KEY) && px < SW && py < SH) begin
          exp_addr_q.push_back(py*SW + px);
          exp_data_q.push_back(c);
          exp_cost += 3;
        end else begin
          exp_cost += 2;
        end
      end
    end
  endtask

  task automatic run_sprite(input string name, input int id, input int x, input int y,
                            input bit combined, input int hold_extra, input bit use_noise);
    int w0, d0, s0, we0, h0, start, mism, n;
    bit seen;
    w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
    s0 = stall_cnt; we0 = we_cnt; h0 = hold_viol;
    model(id, x, y);
    UPDATE = 1'b1; SPRITE_ID = id[1:0]; TARGET_X = x[8:0]; TARGET_Y = y[8:0];
    RUN_ENG = combined;
    if (!combined) begin
      tick();
      RUN_ENG = 1'b1;
    end
    start = cyc;
    noise = use_noise;
    for (int i = 0; i < 6000 && done_cyc_q.size() == d0; i++) tick();
    noise = 1'b0;
    UPDATE = 1'b0;
    for (int i = 0; i < hold_extra; i++) tick();
    RUN_ENG = 1'b0;
    tick();
    tick();
    seen = done_cyc_q.size() > d0;
    check({name, " done seen"}, int'(seen), 1);
    r_done_rel = seen ? done_cyc_q[d0] - start : -1;
    r_stalls = stall_cnt - s0;
    r_we = we_cnt - we0;
    r_hold = hold_viol - h0;
    check({name, " done cycle vs model"}, r_done_rel, 1 + exp_cost + r_stalls);
    check({name, " done pulses"}, done_cyc_q.size() - d0, 1);
    r_writes = wr_addr_q.size() - w0;
    check({name, " write count vs model"}, r_writes, exp_addr_q.size());
    n = (r_writes < exp_addr_q.size()) ? r_writes : exp_addr_q.size();
    mism = 0;
    for (int i = 0; i < n; i++)
      if (wr_addr_q[w0+i] != exp_addr_q[i] || wr_data_q[w0+i] != exp_data_q[i]) mism++;
    check({name, " write addr/data mismatches"}, mism, 0);
    r_first = (r_writes > 0) ? wr_addr_q[w0] : -1;
    r_last = (r_writes > 0) ? wr_addr_q[wr_addr_q.size()-1] : -1;
    r_last_data = (r_writes > 0) ? wr_data_q[wr_data_q.size()-1] : -1;
  endtask

  typedef struct {
    string name;
    int id, x, y, fill_mode, color;
    int exp_done, exp_writes, exp_first, exp_last;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input int id, input int x, input int y,
                         input int fm, input int color, input int ed, input int ew,
                         input int ef, input int el);
    vec_t v;
    v.name = name; v.id = id; v.x = x; v.y = y; v.fill_mode = fm; v.color = color;
    v.exp_done = ed; v.exp_writes = ew; v.exp_first = ef; v.exp_last = el;
    vecs.push_back(v);
  endtask

  initial begin
    int d_before;
    vec_t v;
    bit we_seen;

    add_vec("t1_transparent", 0, 0,   0,   0, 0,     513, 0,   -1,    -1);
    add_vec("t2_opaque",      0, 10,  20,  1, 'h1C,  769, 256, 6410,  11225);
    add_vec("t3_clip",        2, 312, 232, 1, 'h1C,  577, 64,  74552, 76799);
    add_vec("corner_pixel",   1, 319, 239, 1, 'h55,  514, 1,   76799, 76799);
    add_vec("x_overflow",     1, 511, 0,   1, 'h42,  513, 0,   -1,    -1);
    add_vec("y_overflow",     2, 0,   500, 1, 'h42,  513, 0,   -1,    -1);

    for (int i = 0; i < 1024; i++) rom_mem[i] = KEY;

    RESET_L = 1'b0;
    tick(); tick(); tick();
    check("reset FB_WE", int'(FB_WE), 0);
    check("reset FB_ADDR", int'(FB_ADDR), 0);
    check("reset FB_DATA", int'(FB_DATA), 0);
    check("reset ROM_ADDR", int'(ROM_ADDR), 0);
    check("reset ENG_DONE", int'(ENG_DONE), 0);
    RESET_L = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      fill(v.id, v.fill_mode, v.color);
      ready_mode = 0;
      run_sprite(v.name, v.id, v.x, v.y, 1'b0, 3, 1'b0);
      check({v.name, " done cycle"}, r_done_rel, v.exp_done);
      check({v.name, " writes"}, r_writes, v.exp_writes);
      check({v.name, " FB_WE cycles"}, r_we, v.exp_writes);
      if (v.exp_writes > 0) begin
        check({v.name, " first addr"}, r_first, v.exp_first);
        check({v.name, " last addr"}, r_last, v.exp_last);
        check({v.name, " last data"}, r_last_data, v.color);
      end
    end
    check("no addr beyond screen", int'(max_addr < 76800), 1);

    fill(1, 1, 'h1C);
    ready_mode = 2;
    stall_left = 5;
    run_sprite("t4_stall", 1, 10, 20, 1'b0, 2, 1'b0);
    check("t4 done cycle", r_done_rel, 774);
    check("t4 stall cycles", r_stalls, 5);
    check("t4 hold stable", r_hold, 0);
    check("t4 writes", r_writes, 256);
    check("t4 first addr", r_first, 6410);
    ready_mode = 0;

    run_sprite("t5_skip", 3, 40, 40, 1'b1, 20, 1'b0);
    check("t5 done cycle", r_done_rel, 1);
    check("t5 writes", r_writes, 0);
    check("t5 FB_WE cycles", r_we, 0);

    fill(1, 1, 'h77);
    ready_mode = 2;
    stall_left = 100000;
    UPDATE = 1'b1; SPRITE_ID = 2'd1; TARGET_X = 9'd100; TARGET_Y = 9'd50;
    RUN_ENG = 1'b1;
    tick();
    we_seen = 1'b0;
    for (int i = 0; i < 20 && !we_seen; i++) begin
      if (FB_WE) we_seen = 1'b1;
      else tick();
    end
    check("t6 write pending before reset", int'(we_seen), 1);
    d_before = done_cyc_q.size();
    RESET_L = 1'b0;
    RUN_ENG = 1'b0;
    tick();
    check("t6 FB_WE after reset", int'(FB_WE), 0);
    check("t6 FB_ADDR after reset", int'(FB_ADDR), 0);
    check("t6 FB_DATA after reset", int'(FB_DATA), 0);
    check("t6 ROM_ADDR after reset", int'(ROM_ADDR), 0);
    check("t6 ENG_DONE after reset", int'(ENG_DONE), 0);
    RESET_L = 1'b1;
    ready_mode = 0;
    stall_left = 0;
    tick(); tick();
    check("t6 no done from aborted draw", done_cyc_q.size() - d_before, 0);
    run_sprite("t6_after_reset", 1, 5, 0, 1'b0, 1, 1'b0);
    check("t6 first addr", r_first, 5);
    check("t6 done cycle", r_done_rel, 769);

    for (int i = 0; i < 3; i++) fill(i, 2, 0);
    ready_mode = 1;
    for (int t = 0; t < 8; t++) begin
      int rid, rx, ry;
      rid = $urandom_range(0, 2);
      rx = ($urandom_range(0, 5) == 0) ? $urandom_range(400, 511) : $urandom_range(0, 330);
      ry = ($urandom_range(0, 5) == 0) ? $urandom_range(400, 511) : $urandom_range(0, 250);
      run_sprite($sformatf("rand%0d", t), rid, rx, ry, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    ready_mode = 0;

    check("hold violations overall", hold_viol, 0);
    check("max FB_ADDR on screen", int'(max_addr < 76800), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
